// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial wide adder: one shared 4-bit ripple slice, LSB nibble first, carry registered between nibbles.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN (adds the 'sub' input).

module fourBitAdd (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = ci_i;
        for (int unsigned k = 0; k < 4; k++) begin
            s_o[k]   = a_i[k] ^ b_i[k] ^ c[k];
            c[k+1]   = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
        end
        co_o = c[4];
    end

endmodule

module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   Cout
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      work_q, work_d;
    logic [W-1:0]      s_q, s_d;
    logic              cout_q, cout_d;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic              sub_q, sub_d;
`endif

    logic [3:0]        a_nib, b_nib, slice_s;
    logic              slice_co;

    // Select the active nibble with constant part-selects to keep the mux width-clean.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
`ifdef NIBBLE_SERIAL_SUB_EN
        b_nib = b_nib ^ {4{sub_q}};
`endif
    end

    fourBitAdd u_slice (
        .a_i  (a_nib),
        .b_i  (b_nib),
        .ci_i (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef NIBBLE_SERIAL_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : Cin;
`else
                    carry_d = Cin;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < NIBBLES; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        work_d[4*k +: 4] = slice_s;
                    end
                end
                carry_d = slice_co;
                if (idx_q == LAST) begin
                    s_d     = work_d;
                    cout_d  = slice_co;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a result scoreboard; also exercises a NIBBLES=1 instance.

module tb_nibble_serial_add_ctrl;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst, start, Cin;
    logic [15:0] A, B, S;
    logic        busy, done, Cout;
    logic        sub;

    logic        start1;
    logic [3:0]  A1, B1, S1;
    logic        Cin1, busy1, done1, Cout1;
    logic        sub1;

    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .A     (A1),
        .B     (B1),
        .Cin   (Cin1),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .S     (S1),
        .Cout  (Cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b} + {16'd0, cin};
    endfunction

    // Every done cycle must deliver the oldest outstanding expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                chk("unexpected done", 32'd1, 32'd0);
            end else begin
                chk("result", {15'd0, Cout, S}, {15'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic s);
        A = a; B = b; Cin = cin; sub = s; start = 1'b1;
        tick();
        sb.push_back(model(a, b, cin, s));
        start = 1'b0;
    endtask

    task automatic wait_busy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk({tag, " busy cycles"}, n, exp_cycles);
        chk({tag, " done pulse"}, {31'd0, done}, 32'd1);
        tick();
        chk({tag, " done width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int d0, n;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        start1 = 1'b0; A1 = '0; B1 = '0; Cin1 = 1'b0; sub1 = 1'b0;
        tick(); tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset S", {16'd0, S}, 32'd0);
        chk("reset Cout", {31'd0, Cout}, 32'd0);
        rst = 1'b0;
        tick();

        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_busy("basic", N);
        chk("basic S", {15'd0, Cout, S}, 32'h0_5555);

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_busy("ripple", N);
        chk("ripple S", {15'd0, Cout, S}, 32'h1_0000);

        // Back-to-back: start held high from the last RUN cycle through DONE.
        issue(16'h0000, 16'h0000, 1'b1, 1'b0);
        tick(); tick(); tick();
        A = 16'h0F0F; B = 16'h00F1; Cin = 1'b0; start = 1'b1;
        tick();
        chk("b2b first done", {31'd0, done}, 32'd1);
        chk("b2b first S", {15'd0, Cout, S}, 32'h0_0001);
        tick();
        sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0, 1'b0));
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk("b2b S hold", {16'd0, S}, 32'h0001);
            n++;
            tick();
        end
        chk("b2b busy cycles", n, N);
        chk("b2b second S", {15'd0, Cout, S}, 32'h0_1000);
        tick();

        // Start pulse during RUN must be ignored.
        d0 = done_seen;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        A = 16'hAAAA; B = 16'hAAAA; start = 1'b1;
        tick();
        start = 1'b0;
        wait_busy("ignore", N - 2);
        repeat (6) tick();
        chk("ignore S", {15'd0, Cout, S}, 32'h0_3333);
        chk("ignore single done", done_seen - d0, 1);

        // Reset after the second RUN edge aborts the operation.
        d0 = done_seen;
        A = 16'h7777; B = 16'h7777; Cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort async busy", {31'd0, busy}, 32'd0);
        chk("abort async S", {16'd0, S}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort S", {15'd0, Cout, S}, 32'd0);
        chk("abort no done", done_seen - d0, 0);

        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_busy("fresh", N);
        chk("fresh S", {15'd0, Cout, S}, 32'h1_0000);

        issue(16'hABCD, 16'h9876, 1'b1, 1'b0);
        wait_busy("mixed", N);
        chk("mixed S", {15'd0, Cout, S}, 32'h1_4444);

`ifdef NIBBLE_SERIAL_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_busy("sub borrow", N);
        chk("sub borrow S", {15'd0, Cout, S}, 32'h0_FFFE);
        issue(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_busy("sub noborrow", N);
        chk("sub noborrow S", {15'd0, Cout, S}, 32'h1_0002);
`endif

        // Single-nibble instance: one RUN cycle, done one edge after start.
        A1 = 4'h9; B1 = 4'h8; Cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1 busy", {31'd0, busy1}, 32'd1);
        chk("n1 done early", {31'd0, done1}, 32'd0);
        tick();
        chk("n1 done", {31'd0, done1}, 32'd1);
        chk("n1 S", {27'd0, Cout1, S1}, 32'h12);
        tick();
        chk("n1 idle", {30'd0, busy1, done1}, 32'd0);

        repeat (3) tick();
        chk("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
